// File: rtl/barrelshifter_left_seq32.sv
// -----------------------------------------------------------------------------
// barrelshifter_left_seq32
//
// Multi-cycle logical left shifter. This is the left-direction partner of the
// datapath's right barrel shifter, and it serves SLL/SLLV and left-fill
// operations.
//
// How it works:
//   - One bit of the shift amount is resolved per cycle. Stage k shifts by 2^k
//     when amt[k] is set.
//   - The vacated LSBs take the captured make_up fill bit.
//   - Latency is fixed at SHAMT_W shift cycles plus a one-cycle DONE state,
//     whatever the shift amount.
//
// Optional feature (macro SHL_ROTATE_EN):
//   - When defined, rotate=1 turns each stage into a rotate-left. The bits that
//     leave the top re-enter at the bottom, and make_up is ignored.
//   - When undefined, the rotate port is accepted but has no effect, and no
//     rotate logic is built.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request; accepted only in IDLE or DONE
//   a        in   WIDTH    operand, sampled on accept
//   shift    in   SHAMT_W  left-shift amount, sampled on accept
//   make_up  in   1        fill bit for vacated LSBs, sampled on accept
//   rotate   in   1        rotate-left select (SHL_ROTATE_EN builds only)
//   busy     out  1        high while shifting
//   done     out  1        one-cycle pulse; out is valid from this cycle
//   out      out  WIDTH    result; holds until the next operation completes
// -----------------------------------------------------------------------------
module barrelshifter_left_seq32 #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shift,
   input  logic               make_up,
   input  logic               rotate,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [SHAMT_W-1:0] amt_q, amt_d;
   logic [SHAMT_W-1:0] k_q, k_d;
   logic               fill_q, fill_d;

   logic               accept;
   logic               last_stage;
   logic [WIDTH-1:0]   stage_res [SHAMT_W];
   logic [WIDTH-1:0]   stage_sel;

   // A new request is taken whenever no shift is in progress, including the
   // DONE cycle, so back-to-back operations issue every SHAMT_W+1 cycles.
   assign accept     = start && (state_q != S_SHIFT);
   assign last_stage = (k_q == SHAMT_W'(SHAMT_W - 1));

`ifdef SHL_ROTATE_EN
   logic rot_q, rot_d;
`else
   // The rotate input is kept for port compatibility only.
   logic unused_rotate;
   assign unused_rotate = rotate;
`endif

   // Every stage candidate is built in parallel. Only the one selected by k_q
   // is committed each cycle.
   for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      logic [STEP-1:0] low_bits;
`ifdef SHL_ROTATE_EN
      assign low_bits = rot_q ? acc_q[WIDTH-1 -: STEP] : {STEP{fill_q}};
`else
      assign low_bits = {STEP{fill_q}};
`endif
      assign stage_res[gi] = amt_q[gi] ? {acc_q[WIDTH-1-STEP:0], low_bits} : acc_q;
   end

   always_comb begin
      stage_sel = acc_q;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (k_q == SHAMT_W'(i)) begin
            stage_sel = stage_res[i];
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = start ? S_SHIFT : S_IDLE;
         S_SHIFT: state_d = last_stage ? S_DONE : S_SHIFT;
         S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q == S_SHIFT);
      done = (state_q == S_DONE);
      out  = out_q;
   end

   // ---------------- Datapath next-state ----------------
   always_comb begin
      acc_d  = acc_q;
      amt_d  = amt_q;
      fill_d = fill_q;
      k_d    = k_q;
      out_d  = out_q;
`ifdef SHL_ROTATE_EN
      rot_d  = rot_q;
`endif
      if (accept) begin
         acc_d  = a;
         amt_d  = shift;
         fill_d = make_up;
         k_d    = '0;
`ifdef SHL_ROTATE_EN
         rot_d  = rotate;
`endif
      end else if (state_q == S_SHIFT) begin
         acc_d = stage_sel;
         k_d   = last_stage ? '0 : k_q + 1'b1;
         // out changes only here, so it stays stable through IDLE/DONE and
         // throughout the next operation.
         if (last_stage) begin
            out_d = stage_sel;
         end
      end
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         amt_q  <= '0;
         fill_q <= 1'b0;
         k_q    <= '0;
         out_q  <= '0;
`ifdef SHL_ROTATE_EN
         rot_q  <= 1'b0;
`endif
      end else begin
         acc_q  <= acc_d;
         amt_q  <= amt_d;
         fill_q <= fill_d;
         k_q    <= k_d;
         out_q  <= out_d;
`ifdef SHL_ROTATE_EN
         rot_q  <= rot_d;
`endif
      end
   end

endmodule

// File: tb/tb_barrelshifter_left_seq32.sv
// -----------------------------------------------------------------------------
// Testbench for barrelshifter_left_seq32.
//
// A cycle-level reference model follows the request/done protocol. A compare
// process checks busy, done and out against that model on every falling edge.
// Directed operations also check the result against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_barrelshifter_left_seq32;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [SHAMT_W-1:0] shift;
   logic               make_up;
   logic               rotate;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   out;

   int n_cmp;
   int n_err;
   bit chk_en;

   barrelshifter_left_seq32 #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .shift   (shift),
      .make_up (make_up),
      .rotate  (rotate),
      .busy    (busy),
      .done    (done),
      .out     (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result, computed with plain arithmetic.
   function automatic logic [31:0] ref_shl(input logic [31:0] va, input int sh,
                                           input logic mu, input logic rot);
      logic [63:0] wide;
      logic [31:0] mask;
      wide = {32'b0, va} << sh;
      mask = mu ? ((32'h1 << sh) - 32'h1) : 32'h0;
`ifdef SHL_ROTATE_EN
      if (rot) begin
         return (sh == 0) ? va : (wide[31:0] | (va >> (32 - sh)));
      end
`else
      if (rot) begin
         // rotate has no effect in this build
      end
`endif
      return wide[31:0] | mask;
   endfunction

   // Cycle-level model: a request is taken whenever no operation is pending.
   // The result then appears with done SHAMT_W edges later.
   int          m_cnt;
   logic [31:0] m_pend;
   logic [31:0] m_out;
   logic        m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_out  <= '0;
         m_done <= 1'b0;
         m_pend <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt == 0) begin
            if (start) begin
               m_pend <= ref_shl(a, int'(shift), make_up, rotate);
               m_cnt  <= SHAMT_W;
            end
         end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_out  <= m_pend;
               m_done <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_cnt != 0));
         check("done", 32'(done), 32'(m_done));
         check("out",  out, m_out);
      end
   end

   // Issue one operation, then scramble the operand inputs while it is shifting.
   // Returns the result and the number of falling edges from accept to done.
   task automatic run_op(input logic [31:0] ia, input logic [4:0] ish, input logic imu,
                         input logic irot, output logic [31:0] res, output int lat);
      @(posedge clk);
      #2;
      a = ia; shift = ish; make_up = imu; rotate = irot; start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0; a = $urandom; shift = 5'($urandom); make_up = 1'($urandom);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
      res = out;
      $display("op a=%h shift=%0d make_up=%0b rotate=%0b -> out=%h lat=%0d",
               ia, ish, imu, irot, res, lat);
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      int          gap;
      int          dones;
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rm, rr;

      n_cmp = 0; n_err = 0; chk_en = 1'b0;
      rst_n = 1'b0; start = 1'b0; a = '0; shift = '0; make_up = 1'b0; rotate = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_out",  out, 32'd0);
      @(posedge clk); #2; rst_n = 1'b1; chk_en = 1'b1;

      // Maximum shift with zero fill, plus the fixed-latency check.
      run_op(32'h0000_0001, 5'd31, 1'b0, 1'b0, res, lat);
      check("sh31_out", res, 32'h8000_0000);
      check("latency", 32'(lat), 32'd6);

      run_op(32'h1234_5678, 5'd4, 1'b1, 1'b0, res, lat);
      check("sh4_fill1", res, 32'h2345_678F);
      run_op(32'h1234_5678, 5'd0, 1'b1, 1'b0, res, lat);
      check("sh0_out", res, 32'h1234_5678);
      check("sh0_latency", 32'(lat), 32'd6);
      run_op(32'hFFFF_FFFE, 5'd31, 1'b1, 1'b0, res, lat);
      check("sh31_fill1", res, 32'h7FFF_FFFF);

      // Start held through busy with a changing a: exactly one done, from the first a.
      @(posedge clk); #2;
      a = 32'hDEAD_BEEF; shift = 5'd8; make_up = 1'b0; rotate = 1'b0; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
         a = $urandom; shift = 5'($urandom); make_up = 1'($urandom);
      end
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("held_start_dones", 32'(dones), 32'd1);
      check("held_start_out", out, 32'hADBE_EF00);
      $display("op held-start a=deadbeef shift=8 -> out=%h dones=%0d", out, dones);

      // Back-to-back: a start presented in the DONE cycle is accepted.
      run_op(32'h0000_00FF, 5'd8, 1'b0, 1'b0, res, lat);
      check("b2b_first", res, 32'h0000_FF00);
      a = 32'hF0F0_F0F0; shift = 5'd16; make_up = 1'b1; rotate = 1'b0; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      gap = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) break;
         gap++;
      end
      check("b2b_gap", 32'(gap), 32'd6);
      check("b2b_second", out, 32'hF0F0_FFFF);
      $display("op b2b a=f0f0f0f0 shift=16 make_up=1 -> out=%h gap=%0d", out, gap);

      // Rotate select.
      run_op(32'h8000_0001, 5'd1, 1'b0, 1'b1, res, lat);
`ifdef SHL_ROTATE_EN
      check("rotate_on", res, 32'h0000_0003);
`else
      check("rotate_ignored", res, 32'h0000_0002);
`endif

      // Reset asserted mid-operation: immediate abort and no done afterwards.
      @(posedge clk); #2;
      a = 32'h0F0F_0F0F; shift = 5'd3; make_up = 1'b1; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      @(posedge clk); #1; rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_out",  out, 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2; rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      $display("op reset-abort -> out=%h dones=%0d", out, dones);

      // Random operations, checked by the compare process and directly.
      for (int n = 0; n < 2000; n++) begin
         ra = $urandom; rs = 5'($urandom); rm = 1'($urandom); rr = 1'($urandom);
         run_op(ra, rs, rm, rr, res, lat);
         check("rand_out", res, ref_shl(ra, int'(rs), rm, rr));
      end

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
      $fatal(1, "watchdog");
   end

endmodule
